bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/timer_pkg.sv | 8 +
 rtl/bcd_digit_down.sv | 25 ++
 rtl/bcd_countdown_timer.sv | 92 +++++++++
 tb/tb_bcd_countdown_timer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM state, BCD digit type and digit range limits for bcd_countdown_timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd5;
  localparam bcd_t BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one BCD down-counting digit that wraps 0 -> MAX and signals a borrow to the next stage
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic ld,
  input  bcd_t ld_val,
  input  logic bin,
  output bcd_t q,
  output logic bout,
  output logic zero
);
  bcd_t q_q, q_d;
  assign q = q_q;
  assign zero = q_q == 4'd0;
  assign bout = bin & zero;
  always_comb q_d = clr ? 4'd0 : ld ? ld_val : bin ? (zero ? MAX : q_q - 4'd1) : q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= 4'd0;
    else q_q <= q_d;
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: mm:ss BCD countdown with start/stop/clear/load pulses.
// Define TIMER_AUTORELOAD_EN to reload the last accepted preset on reaching 00:00.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_min_D1,
  input  logic [3:0] load_min_D0,
  input  logic [3:0] load_sec_D1,
  input  logic [3:0] load_sec_D0,
  output logic [3:0] min_D1,
  output logic [3:0] min_D0,
  output logic [3:0] sec_D1,
  output logic [3:0] sec_D0,
  output logic       running,
  output logic       expired,
  output logic       load_err
);
  localparam int PW = $clog2(TICK_DIV);
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic expired_q, expired_d, load_err_q, load_err_d;
  logic [15:0] preset, ld_val;
  logic z0, z1, z2, z3, b1, b2, b3, b4;
  logic preset_ok, idle_like, cmd_load, load_acc, go, run_adv, tick, dec, ld;
  logic time_zero, hit_zero, reload_take, reload_zero, to_expired;
  assign preset = {load_min_D1, load_min_D0, load_sec_D1, load_sec_D0};
  assign preset_ok = load_sec_D0 <= BCD_MAX && load_sec_D1 <= SEC_TENS_MAX &&
                     load_min_D0 <= BCD_MAX && load_min_D1 <= MIN_TENS_MAX;
  assign time_zero = z0 & z1 & z2 & z3;
  assign idle_like = state_q != RUN;
  assign cmd_load = load & ~clear & ~stop & ~start;
  assign load_acc = cmd_load & idle_like & preset_ok;
  assign go = start & ~clear & ~stop & idle_like & ~time_zero;
  assign run_adv = state_q == RUN && !clear && !stop;
  assign tick = run_adv && presc_q == PW'(TICK_DIV - 1);
  assign hit_zero = tick & (sec_D0 == 4'd1) & z1 & z2 & z3;
  assign dec = tick & ~time_zero & ~reload_take;
  assign ld = load_acc | reload_take;
  assign to_expired = hit_zero & reload_zero;
`ifdef TIMER_AUTORELOAD_EN
  logic [15:0] rl_q, rl_d;
  assign reload_take = hit_zero;
  assign reload_zero = rl_q == 16'd0;
  assign ld_val = reload_take ? rl_q : preset;
  always_comb rl_d = load_acc ? preset : rl_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rl_q <= 16'd0;
    else rl_q <= rl_d;
`else
  assign reload_take = 1'b0;
  assign reload_zero = 1'b1;
  assign ld_val = preset;
`endif
  // borrow ripples sec ones -> sec tens -> min ones -> min tens
  bcd_digit_down #(.MAX(BCD_MAX)) u_sec0 (.clk(clk), .rst_n(rst_n), .clr(clear), .ld(ld),
    .ld_val(ld_val[3:0]), .bin(dec), .q(sec_D0), .bout(b1), .zero(z0));
  bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_sec1 (.clk(clk), .rst_n(rst_n), .clr(clear), .ld(ld),
    .ld_val(ld_val[7:4]), .bin(b1), .q(sec_D1), .bout(b2), .zero(z1));
  bcd_digit_down #(.MAX(BCD_MAX)) u_min0 (.clk(clk), .rst_n(rst_n), .clr(clear), .ld(ld),
    .ld_val(ld_val[11:8]), .bin(b2), .q(min_D0), .bout(b3), .zero(z2));
  bcd_digit_down #(.MAX(MIN_TENS_MAX)) u_min1 (.clk(clk), .rst_n(rst_n), .clr(clear), .ld(ld),
    .ld_val(ld_val[15:12]), .bin(b3), .q(min_D1), .bout(b4), .zero(z3));
  always_comb begin
    state_d = clear ? IDLE : (stop && state_q == RUN) ? PAUSED : go ? RUN : to_expired ? EXPIRED : state_q;
    presc_d = (clear || go) ? '0 : run_adv ? (tick ? '0 : presc_q + 1'b1) : presc_q;
    expired_d = hit_zero | b4;
    load_err_d = cmd_load & idle_like & ~preset_ok;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      expired_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      expired_q <= expired_d;
      load_err_q <= load_err_d;
    end
  assign running = state_q == RUN;
  assign expired = expired_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: scoreboard bench; a seconds-based model predicts every cycle's outputs
module tb_bcd_countdown_timer;
  localparam int TD = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_EXP = 3;
  logic clk = 1'b0, rst_n = 1'b1;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
  logic [3:0] load_min_D1 = 4'd0, load_min_D0 = 4'd0, load_sec_D1 = 4'd0, load_sec_D0 = 4'd0;
  logic [3:0] min_D1, min_D0, sec_D1, sec_D0;
  logic running, expired, load_err;
  int n_cmp = 0, n_bad = 0;
  logic [18:0] sb [$];
  int m_t = 0, m_p = 0, m_st = S_IDLE;
  bit m_exp = 1'b0, m_err = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
  int m_rl = 0;
`endif

  always #5 clk = ~clk;

  bcd_countdown_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .load(load),
    .load_min_D1(load_min_D1), .load_min_D0(load_min_D0),
    .load_sec_D1(load_sec_D1), .load_sec_D0(load_sec_D0),
    .min_D1(min_D1), .min_D0(min_D0), .sec_D1(sec_D1), .sec_D0(sec_D0),
    .running(running), .expired(expired), .load_err(load_err)
  );

  function automatic logic [18:0] snap();
    return {min_D1, min_D0, sec_D1, sec_D0, running, expired, load_err};
  endfunction

  function automatic logic [18:0] model_snap();
    int m = m_t / 60;
    int s = m_t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), m_st == S_RUN, m_exp, m_err};
  endfunction

  task automatic chk(input string nm, input logic [18:0] got, input logic [18:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got mm:ss/run/exp/err=%h required %h", nm, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_p = 0; m_st = S_IDLE; m_exp = 1'b0; m_err = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
    m_rl = 0;
`endif
  endtask

  task automatic model_step(input logic c, s, g, l, input logic [3:0] m1, m0, s1, s0);
    m_exp = 1'b0;
    m_err = 1'b0;
    if (c) begin
      m_t = 0; m_p = 0; m_st = S_IDLE;
    end else if (m_st == S_RUN) begin
      if (s) m_st = S_PAUSED;
      else if (m_p == TD - 1) begin
        m_p = 0;
        m_t = m_t - 1;
        if (m_t == 0) begin
          m_exp = 1'b1;
          m_st = S_EXP;
`ifdef TIMER_AUTORELOAD_EN
          if (m_rl != 0) begin m_t = m_rl; m_st = S_RUN; end
`endif
        end
      end else m_p++;
    end else if (!s) begin
      if (g) begin
        if (m_t != 0) begin m_st = S_RUN; m_p = 0; end
      end else if (l) begin
        if (m1 <= 5 && m0 <= 9 && s1 <= 5 && s0 <= 9) begin
          m_t = (int'(m1) * 10 + int'(m0)) * 60 + int'(s1) * 10 + int'(s0);
`ifdef TIMER_AUTORELOAD_EN
          m_rl = m_t;
`endif
        end else m_err = 1'b1;
      end
    end
  endtask

  task automatic step(input logic c, s, g, l, input logic [3:0] m1, m0, s1, s0);
    clear = c; stop = s; start = g; load = l;
    load_min_D1 = m1; load_min_D0 = m0; load_sec_D1 = s1; load_sec_D0 = s0;
    model_step(c, s, g, l, m1, m0, s1, s0);
    @(posedge clk);
    #1;
    sb.push_back(model_snap());
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic do_load(input logic [3:0] m1, m0, s1, s0);
    step(1'b0, 1'b0, 1'b0, 1'b1, m1, m0, s1, s0);
  endtask

  task automatic do_start();
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic async_reset();
    clear = 1'b0; stop = 1'b0; start = 1'b0; load = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", snap(), 19'd0);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      sb.push_back(model_snap());
    end
    rst_n = 1'b1;
  endtask

  always @(negedge clk)
    if (sb.size() != 0) chk("cycle", snap(), sb.pop_front());

  initial begin
    int r;
    logic [3:0] a, b, c, d;
    #1 rst_n = 1'b0;
    #2 chk("reset_state", snap(), 19'd0);
    @(posedge clk);
    #1;
    sb.push_back(model_snap());
    rst_n = 1'b1;
    idle(2);
    do_load(4'd0, 4'd1, 4'd0, 4'd2);
    do_start();
    idle(13);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    do_load(4'd0, 4'd0, 4'd0, 4'd2);
    do_start();
    idle(12);
    do_load(4'd0, 4'd0, 4'd6, 4'd1);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    do_load(4'd0, 4'd0, 4'd3, 4'd0);
    do_start();
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    idle(10);
    do_start();
    idle(6);
    do_load(4'd5, 4'd5, 4'd5, 4'd5);
    do_load(4'd0, 4'd9, 4'd7, 4'd0);
    idle(3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    do_start();
    idle(3);
    do_load(4'd1, 4'd2, 4'd3, 4'd4);
    do_start();
    idle(6);
    async_reset();
    idle(2);
    do_start();
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      a = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 7)) : 4'd0;
      b = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 11)) : 4'd0;
      c = 4'($urandom_range(0, 6));
      d = 4'($urandom_range(0, 10));
      if ($urandom_range(0, 599) == 0) async_reset();
      else if (r < 2) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b, c, d);
      else if (r < 5) step(1'b0, 1'b1, 1'b0, 1'b0, a, b, c, d);
      else if (r < 13) step(1'b0, 1'b0, 1'b1, 1'b0, a, b, c, d);
      else if (r < 22) step(1'b0, 1'b0, 1'b0, 1'b1, a, b, c, d);
      else idle(1);
    end
    idle(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 19'(sb.size()), 19'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
